serial_packet_parser: RTL and testbench

- Sits directly downstream of serial_rx and consumes its o_Rx_DV / o_Rx_Byte pair.
- Frames the incoming byte stream into host command packets: sync byte, length byte, payload, checksum.
- Buffers the payload and verifies the checksum before releasing anything.
- Presents verified payload bytes on a valid/ready stream to the particle-filter command decoder; malformed frames are discarded with an error code.

---
 rtl/serial_packet_parser.sv | 97 +++++++++
 tb/tb_serial_packet_parser.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_packet_parser.sv
// serial_packet_parser: frames sync/length/payload/checksum packets from serial_rx and streams verified payload bytes.
// Optional inter-byte timeout is enabled by defining SERIAL_PARSER_TIMEOUT_EN.
module serial_packet_parser #(
  parameter int MAX_PAYLOAD = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int CLOCK_FREQUENCY = 48000000,
  parameter int TIMEOUT_US = 1000
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Pkt_Valid,
  input  logic       i_Pkt_Ready,
  output logic [7:0] o_Pkt_Data,
  output logic       o_Pkt_Last,
  output logic [7:0] o_Pkt_Len,
  output logic       o_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);
  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHECK, DRAIN} state_t;
  localparam int AW = MAX_PAYLOAD > 1 ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);
  state_t state, state_nx;
  logic [7:0] mem [MAX_PAYLOAD];
  logic [7:0] len, sum, wr, rd;
  logic bad_len, bad_sum, overrun, timeout, err_nx;
  logic [1:0] code_nx;
  assign bad_len = i_Rx_Byte == 8'd0 || i_Rx_Byte > MAX_LEN;
  assign bad_sum = i_Rx_Byte != sum;
`ifdef SERIAL_PARSER_TIMEOUT_EN
  localparam int TIMEOUT_CLKS = CLOCK_FREQUENCY / 1000000 * TIMEOUT_US;
  localparam int CW = TIMEOUT_CLKS > 1 ? $clog2(TIMEOUT_CLKS) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) cnt <= '0;
    else cnt <= (i_Rx_DV || state == IDLE || state == DRAIN) ? '0 : cnt + CW'(1);
  assign timeout = !i_Rx_DV && state inside {LEN, PAYLOAD, CHECK} && cnt == CW'(TIMEOUT_CLKS - 1);
`else
  logic unused_cfg;
  assign unused_cfg = ^{CLOCK_FREQUENCY, TIMEOUT_US};
  assign timeout = 1'b0;
`endif
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) ? LEN : IDLE;
      LEN:     if (i_Rx_DV) state_nx = bad_len ? IDLE : PAYLOAD;
      PAYLOAD: if (i_Rx_DV && wr == len - 8'd1) state_nx = CHECK;
      CHECK:   if (i_Rx_DV) state_nx = bad_sum ? IDLE : DRAIN;
      DRAIN:   if (i_Pkt_Ready && o_Pkt_Last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (timeout) state_nx = IDLE;
  end
  always_comb begin
    o_Pkt_Valid = state == DRAIN;
    o_Pkt_Data = o_Pkt_Valid ? mem[rd[AW-1:0]] : 8'd0;
    o_Pkt_Last = o_Pkt_Valid && rd == len - 8'd1;
    o_Pkt_Len = o_Pkt_Valid ? len : 8'd0;
    overrun = o_Pkt_Valid && i_Rx_DV;
    err_nx = overrun || (state == LEN && i_Rx_DV && bad_len) || (state == CHECK && i_Rx_DV && bad_sum) || timeout;
    code_nx = overrun ? 2'd3 : (state == LEN && i_Rx_DV) ? 2'd1 : (state == CHECK && i_Rx_DV) ? 2'd2 : 2'd0;
  end
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      len <= 8'd0;
      sum <= 8'd0;
      wr <= 8'd0;
      rd <= 8'd0;
      o_Err <= 1'b0;
      o_Err_Code <= 2'd0;
      o_Busy <= 1'b0;
    end else begin
      o_Err <= err_nx;
      o_Err_Code <= err_nx ? code_nx : 2'd0;
      o_Busy <= state_nx != IDLE;
      if (state == LEN && i_Rx_DV && !bad_len) begin
        len <= i_Rx_Byte;
        sum <= i_Rx_Byte;
        wr <= 8'd0;
      end
      if (state == PAYLOAD && i_Rx_DV) begin
        sum <= sum + i_Rx_Byte;
        wr <= wr + 8'd1;
      end
      if (state == CHECK && i_Rx_DV) rd <= 8'd0;
      if (o_Pkt_Valid && i_Pkt_Ready) rd <= rd + 8'd1;
    end
  // payload storage needs no reset; it is only read after being written in the same packet
  always_ff @(posedge i_Clock)
    if (state == PAYLOAD && i_Rx_DV) mem[wr[AW-1:0]] <= i_Rx_Byte;
endmodule

// File: tb/tb_serial_packet_parser.sv
// tb_serial_packet_parser: directed and randomized checks of serial_packet_parser against a queue-based packet model.
module tb_serial_packet_parser;
`ifdef SERIAL_PARSER_TIMEOUT_EN
  localparam int CF = 1000000, TU = 10, TC = 10;
`else
  localparam int CF = 48000000, TU = 1000, TC = 0;
`endif
  logic clk = 0, rst = 1, dv = 0, rdy = 1;
  logic [7:0] rx = 0;
  logic pv, pl, err, busy;
  logic [7:0] pd, plen;
  logic [1:0] code;
  always #5 clk = ~clk;
  serial_packet_parser #(.MAX_PAYLOAD(16), .SYNC_BYTE(8'hA5), .CLOCK_FREQUENCY(CF), .TIMEOUT_US(TU)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rx),
    .o_Pkt_Valid(pv), .i_Pkt_Ready(rdy), .o_Pkt_Data(pd), .o_Pkt_Last(pl), .o_Pkt_Len(plen),
    .o_Err(err), .o_Err_Code(code), .o_Busy(busy));
  int total = 0, passed = 0, cyc = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  // model: framing phase 0=await sync 1=await length 2=payload 3=await checksum; dq holds verified bytes still to drain
  int phase = 0, mlen = 0, quiet = 0, dlen = 0, ne = 0, nc = 0, s = 0;
  logic [7:0] pq[$], dq[$];
  logic perr = 0;
  logic [1:0] pcode = 0;
  logic v;
  int got_d[$], got_l[$], got_len[$], got_cyc[$], got_e[$];
  logic rq[$], seq_q[$];
  logic [7:0] seq[$];
  int rmode = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_valid", int'(pv), 0);
      chk("rst_data", int'(pd), 0);
      chk("rst_last", int'(pl), 0);
      chk("rst_len", int'(plen), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_busy", int'(busy), 0);
      phase = 0; mlen = 0; quiet = 0; perr = 0; pcode = 0;
      pq.delete();
      dq.delete();
    end else begin
      v = dq.size() > 0;
      chk("valid", int'(pv), int'(v));
      if (v) begin
        chk("data", int'(pd), int'(dq[0]));
        chk("last", int'(pl), int'(dq.size() == 1));
        chk("len", int'(plen), dlen);
      end
      chk("err", int'(err), int'(perr));
      if (perr) chk("err_code", int'(code), int'(pcode));
      chk("busy", int'(busy), int'(phase != 0 || v));
      if (pv && rdy) begin
        got_d.push_back(int'(pd)); got_l.push_back(int'(pl)); got_len.push_back(int'(plen)); got_cyc.push_back(cyc);
      end
      if (err) got_e.push_back(int'(code));
      ne = 0; nc = 0;
      if (v && rdy) void'(dq.pop_front());
      if (dv) begin
        quiet = 0;
        if (v) begin ne = 1; nc = 3; end
        else case (phase)
          0: if (rx == 8'hA5) phase = 1;
          1: if (rx == 0 || rx > 16) begin ne = 1; nc = 1; phase = 0; end
             else begin mlen = int'(rx); pq.delete(); phase = 2; end
          2: begin pq.push_back(rx); if (pq.size() == mlen) phase = 3; end
          default: begin
            s = mlen;
            foreach (pq[i]) s += int'(pq[i]);
            if (int'(rx) == s % 256) begin dq = pq; dlen = mlen; end
            else begin ne = 1; nc = 2; end
            phase = 0;
          end
        endcase
      end else if (phase != 0) begin
        if (TC > 0 && quiet == TC - 1) begin ne = 1; nc = 0; phase = 0; quiet = 0; end
        else quiet++;
      end
      perr = 1'(ne);
      pcode = 2'(nc);
    end
  end
  function automatic int gq(input int q[$], input int i);
    return q.size() > i ? q[i] : -1;
  endfunction
  task automatic tick(input logic d, input logic [7:0] b);
    @(posedge clk); #1;
    dv = d;
    rx = d ? b : 8'($urandom);
    rdy = rq.size() > 0 ? rq.pop_front() : (rmode != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask
  task automatic idle(input int n);
    repeat (n) tick(0, 8'd0);
  endtask
  task automatic sendq();
    foreach (seq[i]) tick(1, seq[i]);
    tick(0, 8'd0);
  endtask
  task automatic clr();
    got_d.delete(); got_l.delete(); got_len.delete(); got_cyc.delete(); got_e.delete();
  endtask
  task automatic wait_drain(input int bound);
    int n = 0;
    while ((dq.size() > 0 || pv) && n < bound) begin tick(0, 8'd0); n++; end
    chk("drain_bound", int'(n < bound), 1);
  endtask
  task automatic pkt(input int kind);
    logic [7:0] b[$];
    logic [7:0] sm;
    int n = $urandom_range(1, 16);
    if (kind == 3) b = {8'($urandom)};
    else if (kind == 2) b = {8'hA5, ($urandom_range(0, 1) != 0 ? 8'd0 : 8'($urandom_range(17, 255)))};
    else begin
      b = {8'hA5, 8'(n)};
      sm = 8'(n);
      repeat (n) begin b.push_back(8'($urandom)); sm += b[b.size() - 1]; end
      b.push_back(kind == 1 ? sm ^ 8'($urandom_range(1, 255)) : sm);
    end
    foreach (b[i]) begin
      tick(1, b[i]);
      if ($urandom_range(0, 39) == 0) idle(12);
      else idle($urandom_range(0, 2));
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish within 90000 cycles");
    $fatal(1);
  end
  initial begin
    int n;
    idle(3);
    rst = 0;
    chk("reset_valid", int'(pv), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    clr();
    seq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    sendq(); idle(6);
    chk("A_count", got_d.size(), 3);
    chk("A_d0", gq(got_d, 0), 'h11); chk("A_d1", gq(got_d, 1), 'h22); chk("A_d2", gq(got_d, 2), 'h33);
    chk("A_l0", gq(got_l, 0), 0); chk("A_l1", gq(got_l, 1), 0); chk("A_l2", gq(got_l, 2), 1);
    chk("A_len", gq(got_len, 0), 3);
    chk("A_consecutive", gq(got_cyc, 2) - gq(got_cyc, 0), 2);
    chk("A_errs", got_e.size(), 0);
    clr();
    seq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    sendq(); idle(4);
    chk("B_errs", got_e.size(), 1);
    chk("B_code", gq(got_e, 0), 2);
    chk("B_xfers", got_d.size(), 0);
    chk("B_busy", int'(busy), 0);
    clr();
    seq = {8'h7E, 8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h5A, 8'h5B};
    sendq(); idle(4);
    chk("C_errs", got_e.size(), 2);
    chk("C_code0", gq(got_e, 0), 1); chk("C_code1", gq(got_e, 1), 1);
    chk("C_count", got_d.size(), 1);
    chk("C_d0", gq(got_d, 0), 'h5A); chk("C_l0", gq(got_l, 0), 1); chk("C_len", gq(got_len, 0), 1);
    clr();
    rq = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    seq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    foreach (seq[i]) tick(1, seq[i]);
    idle(8);
    chk("D_count", got_d.size(), 3);
    chk("D_d0", gq(got_d, 0), 'h11); chk("D_d2", gq(got_d, 2), 'h33);
    clr();
    rq = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    foreach (seq[i]) tick(1, seq[i]);
    tick(1, 8'h42);
    idle(8);
    chk("E_errs", got_e.size(), 1);
    chk("E_code", gq(got_e, 0), 3);
    chk("E_count", got_d.size(), 3);
    chk("E_d1", gq(got_d, 1), 'h22);
    clr();
    rq = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    foreach (seq[i]) tick(1, seq[i]);
    tick(0, 8'd0);
    #2 rst = 1;
    #1;
    chk("F_valid", int'(pv), 0); chk("F_busy", int'(busy), 0); chk("F_len", int'(plen), 0);
    tick(0, 8'd0);
    rst = 0;
    clr();
    seq = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    sendq(); idle(4);
    chk("F_count", got_d.size(), 2);
    chk("F_d0", gq(got_d, 0), 'h10); chk("F_d1", gq(got_d, 1), 'h20);
    chk("F_errs", got_e.size(), 0);
`ifdef SERIAL_PARSER_TIMEOUT_EN
    clr();
    tick(1, 8'hA5); tick(1, 8'h03); tick(1, 8'h11);
    n = 0;
    do begin tick(0, 8'd0); n++; end while (!err && n < 30);
    chk("G_edges_after_dv", n - 1, 10);
    chk("G_code", int'(code), 0);
    idle(2);
    chk("G_busy", int'(busy), 0);
`endif
    rmode = 1;
    repeat (250) begin
      n = $urandom_range(0, 9);
      pkt(n < 5 ? 0 : n < 7 ? 1 : n < 8 ? 2 : 3);
      if ($urandom_range(0, 3) != 0) wait_drain(200);
    end
    idle(30);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
